// File: rtl/multicycle_ctrl_pkg.sv
// Shared definitions for the multicycle control unit: opcodes, ALU operation
// codes (also used by the ALU) and the controller state encoding.
package multicycle_ctrl_pkg;

  typedef enum logic [2:0] {
    S_IF  = 3'b000,
    S_ID  = 3'b001,
    S_EX  = 3'b010,
    S_MEM = 3'b011,
    S_WB  = 3'b100
  } state_e;

  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;

  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_OR   = 4'b0001;
  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_SUB  = 4'b0110;
  localparam logic [3:0] ALU_SLT  = 4'b0111;
  localparam logic [3:0] ALU_SRL  = 4'b1000;
  localparam logic [3:0] ALU_SLL  = 4'b1001;
  localparam logic [3:0] ALU_SRA  = 4'b1010;
  localparam logic [3:0] ALU_SLTU = 4'b1011;
  localparam logic [3:0] ALU_XOR  = 4'b1101;

  typedef struct packed {
    logic is_r;
    logic is_i;
    logic is_lw;
    logic is_sw;
    logic is_beq;
  } op_class_t;

  // Anything not matched here leaves every flag clear and behaves as a NOP.
  function automatic op_class_t classify(logic [6:0] opcode);
    op_class_t c;
    c.is_r   = (opcode == OP_R);
    c.is_i   = (opcode == OP_I);
    c.is_lw  = (opcode == OP_LW);
    c.is_sw  = (opcode == OP_SW);
    c.is_beq = (opcode == OP_BEQ);
    return c;
  endfunction

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Control bundle between the multicycle controller and its datapath/memory.
interface multicycle_ctrl_if;
  // No valid/ready handshake: every strobe is qualified by the controller
  // state, and instr must stay stable from IF until the edge that ends WB.
  logic [31:0] instr;
  logic        Zero;
  logic [3:0]  ALUCtrl;
  logic        ALUSrc;
  logic        MemToReg;
  logic        RegWrite;
  logic        MemRead;
  logic        MemWrite;
  logic        PCSrc;
  logic        loadPC;

  modport master (
    input  instr, Zero,
    output ALUCtrl, ALUSrc, MemToReg, RegWrite, MemRead, MemWrite, PCSrc, loadPC
  );

  modport slave (
    output instr, Zero,
    input  ALUCtrl, ALUSrc, MemToReg, RegWrite, MemRead, MemWrite, PCSrc, loadPC
  );
endinterface

// File: rtl/multicycle_ctrl_alu_decoder.sv
// Combinational ALU operation decode from opcode, funct3 and funct7[5].
module alu_decoder
  import multicycle_ctrl_pkg::*;
(
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic       funct7_5,
  output logic [3:0] alu_ctrl
);

  logic [3:0] f3_op;

  always_comb begin
    f3_op = ALU_ADD;
    case (funct3)
      3'b000: f3_op = ALU_ADD;
      3'b001: f3_op = ALU_SLL;
      3'b010: f3_op = ALU_SLT;
      3'b011: f3_op = ALU_SLTU;
      3'b100: f3_op = ALU_XOR;
      3'b101: f3_op = funct7_5 ? ALU_SRA : ALU_SRL;
      3'b110: f3_op = ALU_OR;
      3'b111: f3_op = ALU_AND;
      default: f3_op = ALU_ADD;
    endcase
  end

  // Immediate forms have no SUB: funct7[5] only selects SRAI over SRLI.
  always_comb begin
    alu_ctrl = ALU_ADD;
    case (opcode)
      OP_R:    alu_ctrl = (funct3 == 3'b000 && funct7_5) ? ALU_SUB : f3_op;
      OP_I:    alu_ctrl = f3_op;
      OP_LW:   alu_ctrl = ALU_ADD;
      OP_SW:   alu_ctrl = ALU_ADD;
      OP_BEQ:  alu_ctrl = ALU_SUB;
      default: alu_ctrl = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Five-state multicycle controller (IF, ID, EX, MEM, WB) for the RV32I subset.
// Strobes are decoded from the registered state and the current instruction.
module multicycle_ctrl
  import multicycle_ctrl_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  multicycle_ctrl_if.master  bus,
  output logic [2:0]         state_dbg
);

  state_e    state_q, state_d;
  op_class_t cls;
  logic      in_mem, in_wb;

  always_comb begin
    state_d = S_IF;
    case (state_q)
      S_IF:    state_d = S_ID;
      S_ID:    state_d = S_EX;
      S_EX:    state_d = S_MEM;
      S_MEM:   state_d = S_WB;
      S_WB:    state_d = S_IF;
      default: state_d = S_IF;
    endcase
  end

  // Reset lands in IF, whose strobes are all zero, so an asserted reset
  // kills any memory or register write in the same cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_IF;
    else      state_q <= state_d;
  end

  assign state_dbg = state_q;
  assign cls       = classify(bus.instr[6:0]);
  assign in_mem    = (state_q == S_MEM);
  assign in_wb     = (state_q == S_WB);

  alu_decoder u_alu_decoder (
    .opcode   (bus.instr[6:0]),
    .funct3   (bus.instr[14:12]),
    .funct7_5 (bus.instr[30]),
    .alu_ctrl (bus.ALUCtrl)
  );

  assign bus.ALUSrc   = cls.is_i | cls.is_lw | cls.is_sw;
  assign bus.MemToReg = cls.is_lw;
  assign bus.MemRead  = in_mem & cls.is_lw;
  assign bus.MemWrite = in_mem & cls.is_sw;
  assign bus.RegWrite = in_wb & (cls.is_r | cls.is_i | cls.is_lw);
  assign bus.PCSrc    = in_wb & cls.is_beq & bus.Zero;
  assign bus.loadPC   = in_wb;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: directed instructions plus random
// instruction streams compared every cycle against an instruction-level model.
module tb_multicycle_ctrl;

  typedef struct {
    logic [3:0] alu;
    logic       alusrc, memtoreg, regwrite, memread, memwrite, pcsrc, loadpc;
    logic [2:0] st;
  } obs_t;

  // ALU code by funct3 for the plain (non-SUB/SRA) forms.
  localparam logic [3:0] ALU_LUT [8] = '{4'h2, 4'h9, 4'h7, 4'hB, 4'hD, 4'h8, 4'h1, 4'h0};

  logic       clk;
  logic       rst;
  logic [2:0] state_dbg;
  int         tests_run = 0;
  int         tests_failed = 0;
  int         phase = 0;   // cycle position within the current instruction
  obs_t       obs [5];

  multicycle_ctrl_if bus ();

  multicycle_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .state_dbg (state_dbg)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got timeout required finish");
    $fatal(1, "watchdog");
  end

  always @(posedge clk or negedge rst) begin
    if (!rst) phase <= 0;
    else      phase <= (phase == 4) ? 0 : phase + 1;
  end

  // ---------------- reference model ----------------
  function automatic obs_t model(logic [31:0] ins, int ph, logic z, logic rn);
    obs_t e;
    logic [6:0] op;
    logic [2:0] f3;
    bit r, i, lw, sw, beq, mem, wb;
    op  = ins[6:0];
    f3  = ins[14:12];
    r   = (op == 7'h33);
    i   = (op == 7'h13);
    lw  = (op == 7'h03);
    sw  = (op == 7'h23);
    beq = (op == 7'h63);
    mem = rn && (ph == 3);
    wb  = rn && (ph == 4);
    e.alu = 4'h2;
    if (r || i) begin
      e.alu = ALU_LUT[f3];
      if (f3 == 3'd5 && ins[30]) e.alu = 4'hA;
      if (f3 == 3'd0 && r && ins[30]) e.alu = 4'h6;
    end
    if (beq) e.alu = 4'h6;
    e.alusrc   = i || lw || sw;
    e.memtoreg = lw;
    e.memread  = mem && lw;
    e.memwrite = mem && sw;
    e.regwrite = wb && (r || i || lw);
    e.pcsrc    = wb && beq && z;
    e.loadpc   = wb;
    e.st       = rn ? 3'(ph) : 3'd0;
    return e;
  endfunction

  function automatic obs_t sample();
    obs_t o;
    o.alu      = bus.ALUCtrl;
    o.alusrc   = bus.ALUSrc;
    o.memtoreg = bus.MemToReg;
    o.regwrite = bus.RegWrite;
    o.memread  = bus.MemRead;
    o.memwrite = bus.MemWrite;
    o.pcsrc    = bus.PCSrc;
    o.loadpc   = bus.loadPC;
    o.st       = state_dbg;
    return o;
  endfunction

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s @%0t: got %0h, required %0h", name, $time, act, exp);
    end
  endtask

  // ---------------- scoreboard: every cycle ----------------
  always begin
    obs_t a, e;
    @(negedge clk);
    #3;
    a = sample();
    e = model(bus.instr, phase, bus.Zero, rst);
    check("cyc_alu",      a.alu,      e.alu);
    check("cyc_alusrc",   {3'b0, a.alusrc},   {3'b0, e.alusrc});
    check("cyc_memtoreg", {3'b0, a.memtoreg}, {3'b0, e.memtoreg});
    check("cyc_regwrite", {3'b0, a.regwrite}, {3'b0, e.regwrite});
    check("cyc_memread",  {3'b0, a.memread},  {3'b0, e.memread});
    check("cyc_memwrite", {3'b0, a.memwrite}, {3'b0, e.memwrite});
    check("cyc_pcsrc",    {3'b0, a.pcsrc},    {3'b0, e.pcsrc});
    check("cyc_loadpc",   {3'b0, a.loadpc},   {3'b0, e.loadpc});
    check("cyc_state",    {1'b0, a.st},       {1'b0, e.st});
  end

  // ---------------- driver tasks ----------------
  task automatic align_to_if();
    int guard = 0;
    @(negedge clk);
    while (phase != 0 && guard < 10) begin
      @(negedge clk);
      guard++;
    end
    if (phase != 0) check("align_timeout", 4'(phase), 4'd0);
  endtask

  // Runs one full instruction; obs[p] holds outputs seen in cycle p.
  task automatic run_instr(input logic [31:0] ins, input logic zero_wb, input bit aligned);
    if (!aligned) align_to_if();
    for (int p = 0; p < 5; p++) begin
      if (p > 0) @(negedge clk);
      bus.instr = ins;
      bus.Zero  = (p == 4) ? zero_wb : 1'($urandom_range(0, 1));
      #3;
      obs[p] = sample();
    end
  endtask

  task automatic rand_instr();
    logic [31:0] ins;
    logic [6:0]  ops [6];
    ops = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h00};
    ins = $urandom;
    ops[5] = 7'($urandom);
    ins[6:0] = ops[$urandom_range(0, 5)];
    run_instr(ins, 1'($urandom_range(0, 1)), 1'b0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    bus.instr = 32'h0;
    bus.Zero  = 1'b0;
    rst = 1'b1;
    #1 rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      #3;
      check("rst_loadpc", {3'b0, bus.loadPC}, 4'd0);
      check("rst_state", {1'b0, state_dbg}, 4'd0);
    end
    @(negedge clk);
    rst = 1'b1;
    run_instr(32'h002081B3, 1'b0, 1'b1);   // ADD x3,x1,x2 right after release
    check("first_loadpc_c4", {3'b0, obs[4].loadpc}, 4'd1);
    check("first_loadpc_c3", {3'b0, obs[3].loadpc}, 4'd0);
    check("add_alu", obs[0].alu, 4'h2);
    check("add_alusrc", {3'b0, obs[2].alusrc}, 4'd0);
    check("add_regwrite_wb", {3'b0, obs[4].regwrite}, 4'd1);
    check("add_regwrite_mem", {3'b0, obs[3].regwrite}, 4'd0);
    check("add_memread", {3'b0, obs[3].memread}, 4'd0);
    check("add_memwrite", {3'b0, obs[3].memwrite}, 4'd0);

    run_instr(32'h00812283, 1'b0, 1'b0);   // LW x5,8(x2)
    check("lw_memread_mem", {3'b0, obs[3].memread}, 4'd1);
    check("lw_memread_wb", {3'b0, obs[4].memread}, 4'd0);
    check("lw_memtoreg", {3'b0, obs[1].memtoreg}, 4'd1);
    check("lw_regwrite_wb", {3'b0, obs[4].regwrite}, 4'd1);

    run_instr(32'h00512623, 1'b0, 1'b0);   // SW x5,12(x2)
    check("sw_memwrite_mem", {3'b0, obs[3].memwrite}, 4'd1);
    check("sw_memwrite_ex", {3'b0, obs[2].memwrite}, 4'd0);
    check("sw_regwrite_wb", {3'b0, obs[4].regwrite}, 4'd0);

    run_instr(32'h00208463, 1'b1, 1'b0);   // BEQ taken
    check("beq_z1_pcsrc", {3'b0, obs[4].pcsrc}, 4'd1);
    check("beq_alu", obs[2].alu, 4'h6);
    run_instr(32'h00208463, 1'b0, 1'b0);   // BEQ not taken
    check("beq_z0_pcsrc", {3'b0, obs[4].pcsrc}, 4'd0);
    check("beq_z0_loadpc", {3'b0, obs[4].loadpc}, 4'd1);

    run_instr(32'h40325213, 1'b0, 1'b0);   // SRAI x4,x4,3
    check("srai_alu", obs[2].alu, 4'hA);
    check("srai_alusrc", {3'b0, obs[2].alusrc}, 4'd1);
    run_instr(32'h00321213, 1'b0, 1'b0);   // SLLI
    check("slli_alu", obs[2].alu, 4'h9);

    run_instr(32'h0000007F, 1'b1, 1'b0);   // unknown opcode: NOP
    check("nop_regwrite", {3'b0, obs[4].regwrite}, 4'd0);
    check("nop_memwrite", {3'b0, obs[3].memwrite}, 4'd0);
    check("nop_memread", {3'b0, obs[3].memread}, 4'd0);
    check("nop_pcsrc", {3'b0, obs[4].pcsrc}, 4'd0);
    check("nop_loadpc", {3'b0, obs[4].loadpc}, 4'd1);
    check("nop_alu", obs[2].alu, 4'h2);

    // Reset asserted in the middle of the MEM cycle of a store.
    align_to_if();
    bus.instr = 32'h00512623;
    for (int p = 1; p < 4; p++) @(negedge clk);
    #3;
    check("midrst_memwrite_pre", {3'b0, bus.MemWrite}, 4'd1);
    #1 rst = 1'b0;
    #1;
    check("midrst_memwrite_post", {3'b0, bus.MemWrite}, 4'd0);
    check("midrst_state", {1'b0, state_dbg}, 4'd0);
    repeat (2) @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    run_instr(32'h00512623, 1'b0, 1'b1);
    check("postrst_sw_mem", {3'b0, obs[3].memwrite}, 4'd1);
    check("postrst_loadpc", {3'b0, obs[4].loadpc}, 4'd1);

    for (int n = 0; n < 160; n++) rand_instr();

    @(negedge clk);
    #4;
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
